// File: rtl/output_pulser_if.sv
// Handshake bundle for output_pulser: trigger/count in, pulse state out.
interface output_pulser_if #(
  parameter int N_W = 4
);
  logic           trig;
  logic [N_W-1:0] count;
  logic           out;
  logic           busy;
  logic           done;

  modport master (
    output trig, count,
    input  out, busy, done
  );

  modport slave (
    input  trig, count,
    output out, busy, done
  );
endinterface

// File: rtl/output_pulser.sv
// Turns a one-tick trigger into N blinks of ON_TICKS high / OFF_TICKS low.
// Define OUTPUT_PULSER_RETRIG_EN to let a trigger restart or abort a sequence.
module output_pulser #(
  parameter int ON_TICKS  = 10_000_000,
  parameter int OFF_TICKS = 10_000_000,
  parameter int N_W       = 4
) (
  input  logic            clk,
  input  logic            rst,
  output_pulser_if.slave  bus
);
  localparam int MAX_T = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int T_W   = $clog2(MAX_T + 1);
  localparam logic [T_W-1:0] ON_LD  = T_W'(ON_TICKS - 1);
  localparam logic [T_W-1:0] OFF_LD = T_W'(OFF_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE,
    ON,
    GAP
  } state_e;

  state_e         state_q, state_d;
  logic [T_W-1:0] timer_q, timer_d;
  logic [N_W-1:0] rem_q, rem_d;
  logic           out_q, out_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      rem_q   <= '0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      rem_q   <= rem_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.trig && bus.count != '0) begin
          rem_d   = bus.count;
          timer_d = ON_LD;
          state_d = ON;
        end
      end
      ON: begin
        if (timer_q == '0) begin
          rem_d = rem_q - 1'b1;
          // Last blink ends straight in IDLE; no trailing gap.
          if (rem_q == N_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = GAP;
            timer_d = OFF_LD;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      GAP: begin
        if (timer_q == '0) begin
          state_d = ON;
          timer_d = ON_LD;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
`ifdef OUTPUT_PULSER_RETRIG_EN
    if (bus.trig && state_q != IDLE) begin
      if (bus.count != '0) begin
        state_d = ON;
        rem_d   = bus.count;
        timer_d = ON_LD;
      end else begin
        state_d = IDLE;
        rem_d   = '0;
        timer_d = '0;
      end
      done_d = 1'b0;
    end
`endif
    out_d  = (state_d == ON);
    busy_d = (state_d != IDLE);
  end

  assign bus.out  = out_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_output_pulser.sv
// Directed bench for output_pulser with ON_TICKS=3, OFF_TICKS=2, N_W=4.
// Cycle 0 is the first cycle after reset release.
module tb_output_pulser;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  output_pulser_if #(.N_W(4)) bus ();

  output_pulser #(
    .ON_TICKS (3),
    .OFF_TICKS(2),
    .N_W      (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got, input logic exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] bit1(input int i);
    logic [63:0] m;
    m = '0;
    m[i] = 1'b1;
    return m;
  endfunction

  task automatic run(
    input string       name,
    input int          ncyc,
    input int          t1,
    input logic [3:0]  c1,
    input int          t2,
    input logic [3:0]  c2,
    input int          rst_at,
    input logic [63:0] eo,
    input logic [63:0] eb,
    input logic [63:0] ed
  );
    bus.trig  = 1'b0;
    bus.count = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      chk($sformatf("%s c%0d out", name, c), bus.out, eo[c]);
      chk($sformatf("%s c%0d busy", name, c), bus.busy, eb[c]);
      chk($sformatf("%s c%0d done", name, c), bus.done, ed[c]);
      if (c == rst_at) begin
        rst = 1'b1;
        #1;
        chk($sformatf("%s async out", name), bus.out, 1'b0);
        chk($sformatf("%s async busy", name), bus.busy, 1'b0);
        chk($sformatf("%s async done", name), bus.done, 1'b0);
        rst = 1'b0;
      end
      bus.trig  = (c == t1) || (c == t2);
      bus.count = (c == t1) ? c1 : (c == t2) ? c2 : 4'd0;
      @(posedge clk);
      #1;
      bus.trig  = 1'b0;
      bus.count = '0;
    end
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b1;
    bus.trig  = 1'b0;
    bus.count = '0;

    run("idle", 20, -1, 4'd0, -1, 4'd0, -1, '0, '0, '0);

    run("n1", 20, 10, 4'd1, -1, 4'd0, -1,
        rng(11, 13), rng(11, 13), bit1(14));

    run("n3", 30, 10, 4'd3, -1, 4'd0, -1,
        rng(11, 13) | rng(16, 18) | rng(21, 23),
        rng(11, 23), bit1(24));

    run("n0", 20, 10, 4'd0, -1, 4'd0, -1, '0, '0, '0);

`ifdef OUTPUT_PULSER_RETRIG_EN
    run("retrig", 26, 10, 4'd1, 12, 4'd2, -1,
        rng(11, 15) | rng(18, 20), rng(11, 20), bit1(21));
`else
    run("busytrig", 26, 10, 4'd1, 12, 4'd2, -1,
        rng(11, 13), rng(11, 13), bit1(14));
`endif

    run("rstgap", 32, 10, 4'd2, 20, 4'd2, 15,
        rng(11, 13) | rng(21, 23) | rng(26, 28),
        rng(11, 15) | rng(21, 28), bit1(29));

    run("b2b", 22, 10, 4'd1, 14, 4'd1, -1,
        rng(11, 13) | rng(15, 17), rng(11, 13) | rng(15, 17),
        bit1(14) | bit1(18));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
